// File: rtl/cpu_step_ctrl.sv
// Board execution controller: debounced step/run/view buttons drive a one-cycle CPU clock enable.
// Optional executed-step counter on cycle_cnt_o when CPU_STEP_CYCLE_COUNT_EN is defined.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned VIEW_COUNT      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_step_i,
  input  logic        btn_run_i,
  input  logic        btn_view_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] bp_addr_i,
  input  logic        bp_en_i,
  output logic        cpu_ce_o,
  output logic [2:0]  view_sel_o,
  output logic [1:0]  state_o,
  output logic        halted_o,
  output logic [31:0] cycle_cnt_o
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DivW = $clog2(RUN_DIV + 1);
  localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax  = DivW'(RUN_DIV - 1);
  localparam logic [2:0]      ViewMax = 3'(VIEW_COUNT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StRun  = 2'd2,
    StHalt = 2'd3
  } state_e;

  // Button bit order: 0 = step, 1 = run, 2 = view.
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          level_q, level_d;
  logic [2:0]          press_q, press_d;
  logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic            chk_q;
  logic            sup_q, sup_d;
  logic [2:0]      view_q, view_d;
  logic            bp_hit;

  always_comb begin
    level_d  = level_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sup_d   = sup_q;
    // chk_q marks the cycle after a pulse, when the core PC has advanced.
    bp_hit  = chk_q & bp_en_i & (pc_i == bp_addr_i) & ~sup_q;
    if (chk_q) begin
      sup_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (bp_hit) begin
          state_d = StHalt;
        end else if (press_q[1]) begin
          state_d = StRun;
          div_d   = '0;
        end else if (press_q[0]) begin
          state_d = StStep;
        end
      end
      StStep: state_d = StIdle;
      StRun: begin
        if (bp_hit) begin
          state_d = StHalt;
        end else if (press_q[1]) begin
          state_d = StIdle;
          div_d   = '0;
        end else begin
          div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
        end
      end
      StHalt: begin
        if (press_q[1]) begin
          state_d = StRun;
          div_d   = '0;
        end else if (press_q[0]) begin
          state_d = StStep;
        end
      end
      default: state_d = StIdle;
    endcase
    // Let the core leave the breakpoint address on the first pulse after HALT.
    if (state_q == StHalt && state_d != StHalt) begin
      sup_d = 1'b1;
    end
    cpu_ce_d = (state_d == StStep) |
               ((state_q == StRun) && (state_d == StRun) && (div_d == DivMax));
  end

  always_comb begin
    view_d = view_q;
    if (press_q[2]) begin
      view_d = (view_q == ViewMax) ? 3'd0 : view_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
      state_q  <= StIdle;
      div_q    <= '0;
      cpu_ce_q <= 1'b0;
      chk_q    <= 1'b0;
      sup_q    <= 1'b0;
      view_q   <= '0;
    end else begin
      sync1_q  <= {btn_view_i, btn_run_i, btn_step_i};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      div_q    <= div_d;
      cpu_ce_q <= cpu_ce_d;
      chk_q    <= cpu_ce_q;
      sup_q    <= sup_d;
      view_q   <= view_d;
    end
  end

`ifdef CPU_STEP_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= '0;
    end else if (cpu_ce_q) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cyc_q;
`else
  assign cycle_cnt_o = '0;
`endif

  assign cpu_ce_o   = cpu_ce_q;
  assign view_sel_o = view_q;
  assign state_o    = state_q;
  assign halted_o   = (state_q == StHalt);

endmodule
